// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: datapath widths, register index and word types,
// and the NZP condition-code encodings used by the register file and the
// branch unit.
package lc3_pkg;

    localparam int LC3_WIDTH = 16;
    localparam int LC3_NREGS = 8;

    typedef logic [2:0]           reg_idx_t;
    typedef logic [LC3_WIDTH-1:0] word_t;
    typedef logic [2:0]           nzp_t;

    localparam nzp_t NZP_N = 3'b100;
    localparam nzp_t NZP_Z = 3'b010;
    localparam nzp_t NZP_P = 3'b001;

endpackage

// File: rtl/lc3_nzp_gen.sv
// Combinational classification of a 16-bit word into exactly one of the
// N, Z or P condition codes. Shared by the register file and the branch unit.
module lc3_nzp_gen
    import lc3_pkg::*;
(
    input  word_t value,
    output nzp_t  nzp
);

    // Sign bit wins first, then zero detect, otherwise the value is positive
    always_comb begin
        if (value[LC3_WIDTH-1]) begin
            nzp = NZP_N;
        end else if (value == '0) begin
            nzp = NZP_Z;
        end else begin
            nzp = NZP_P;
        end
    end

endmodule

// File: rtl/lc3_regfile.sv
// LC-3 general-purpose register file: R0-R7, two combinational read ports
// and the NZP condition-code register. Writes are steered by the one-hot
// destination select from the DR decoder; an illegal select (none or more
// than one bit) writes nothing and raises onehot_err for one cycle.
// Optional feature: define REGFILE_BYPASS_EN to forward the write data to a
// read port addressing the register being written in the same cycle.
module lc3_regfile
    import lc3_pkg::*;
#(
    parameter int WIDTH = LC3_WIDTH,
    parameter int NREGS = LC3_NREGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_reg,
    input  logic [NREGS-1:0] dr_onehot,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             ld_cc,
    input  logic [2:0]       sr1,
    input  logic [2:0]       sr2,
    output logic [WIDTH-1:0] sr1_out,
    output logic [WIDTH-1:0] sr2_out,
    output logic [2:0]       nzp,
    output logic             onehot_err
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [3:0]       sel_count;
    reg_idx_t         wr_idx;
    logic             sel_legal;
    logic             wr_en;
    nzp_t             nzp_next;

    // Count the set select bits and encode the selected register index
    always_comb begin
        sel_count = '0;
        wr_idx    = '0;
        for (int i = 0; i < NREGS; i++) begin
            sel_count = sel_count + {3'b000, dr_onehot[i]};
            if (dr_onehot[i]) begin
                wr_idx = reg_idx_t'(i);
            end
        end
        sel_legal = (sel_count == 4'd1);
        wr_en     = ld_reg & sel_legal;
    end

    lc3_nzp_gen u_nzp_gen (
        .value (bus_in),
        .nzp   (nzp_next)
    );

    // Register array: clear on reset, otherwise write the one selected register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_idx] <= bus_in;
        end
    end

    // Condition codes follow bus_in on ld_cc regardless of the write select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzp <= NZP_Z;
        end else if (ld_cc) begin
            nzp <= nzp_next;
        end
    end

    // Error flag reflects only the previous edge, so it self-clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_err <= 1'b0;
        end else begin
            onehot_err <= ld_reg & ~sel_legal;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Read ports forward in-flight write data when addressing the destination
    always_comb begin
        sr1_out = (wr_en && (sr1 == wr_idx)) ? bus_in : regs[sr1];
        sr2_out = (wr_en && (sr2 == wr_idx)) ? bus_in : regs[sr2];
    end
`else
    // Read ports show stored contents only
    always_comb begin
        sr1_out = regs[sr1];
        sr2_out = regs[sr2];
    end
`endif

endmodule

// File: tb/tb_lc3_regfile.sv
// Self-checking bench for lc3_regfile: a table of directed write/read/NZP
// vectors plus hand-written sequences for same-cycle reads and mid-cycle reset.
module tb_lc3_regfile;

    logic        clk;
    logic        rst_n;
    logic        ld_reg;
    logic [7:0]  dr_onehot;
    logic [15:0] bus_in;
    logic        ld_cc;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] sr1_out;
    logic [15:0] sr2_out;
    logic [2:0]  nzp;
    logic        onehot_err;

    int testsRun;
    int failCount;

    typedef struct {
        logic        ldReg;
        logic [7:0]  drOnehot;
        logic [15:0] busIn;
        logic        ldCc;
        logic [2:0]  rd1;
        logic [2:0]  rd2;
        logic [15:0] exp1;
        logic [15:0] exp2;
        logic [2:0]  expNzp;
        logic        expErr;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    lc3_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_reg     (ld_reg),
        .dr_onehot  (dr_onehot),
        .bus_in     (bus_in),
        .ld_cc      (ld_cc),
        .sr1        (sr1),
        .sr2        (sr2),
        .sr1_out    (sr1_out),
        .sr2_out    (sr2_out),
        .nzp        (nzp),
        .onehot_err (onehot_err)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one vector before the edge, then read back after the edge with writes idle
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        ld_reg    = v.ldReg;
        dr_onehot = v.drOnehot;
        bus_in    = v.busIn;
        ld_cc     = v.ldCc;
        @(posedge clk);
        #1;
        ld_reg    = 1'b0;
        ld_cc     = 1'b0;
        dr_onehot = 8'h00;
        sr1       = v.rd1;
        sr2       = v.rd2;
        #1;
        checkOutput($sformatf("vec%0d_sr1", idx), sr1_out, v.exp1);
        checkOutput($sformatf("vec%0d_sr2", idx), sr2_out, v.exp2);
        checkOutput($sformatf("vec%0d_nzp", idx), {13'b0, nzp}, {13'b0, v.expNzp});
        checkOutput($sformatf("vec%0d_err", idx), {15'b0, onehot_err}, {15'b0, v.expErr});
    endtask

    task automatic checkAllZero(input string tag);
        for (int i = 0; i < 8; i++) begin
            sr1 = 3'(i);
            sr2 = 3'(7 - i);
            #1;
            checkOutput($sformatf("%s_r%0d_p1", tag, i), sr1_out, 16'h0000);
            checkOutput($sformatf("%s_r%0d_p2", tag, 7 - i), sr2_out, 16'h0000);
        end
        checkOutput({tag, "_nzp"}, {13'b0, nzp}, 16'h0002);
        checkOutput({tag, "_err"}, {15'b0, onehot_err}, 16'h0000);
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;

        //            ldReg  sel    bus       ldCc  rd1   rd2   exp1      exp2      nzp     err
        vecs[0]  = '{1'b1, 8'h08, 16'h1234, 1'b0, 3'd3, 3'd3, 16'h1234, 16'h1234, 3'b010, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 3'd0, 3'd2, 16'h0000, 16'h0000, 3'b010, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 3'd4, 3'd7, 16'h0000, 16'h0000, 3'b010, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 16'h0000, 1'b0, 3'd1, 3'd5, 16'h0000, 16'h0000, 3'b010, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 16'h8000, 1'b1, 3'd3, 3'd6, 16'h1234, 16'h0000, 3'b100, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 16'h0000, 1'b1, 3'd3, 3'd6, 16'h1234, 16'h0000, 3'b010, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 16'h0001, 1'b1, 3'd3, 3'd6, 16'h1234, 16'h0000, 3'b001, 1'b0};
        vecs[7]  = '{1'b1, 8'h01, 16'h5555, 1'b0, 3'd0, 3'd3, 16'h5555, 16'h1234, 3'b001, 1'b0};
        vecs[8]  = '{1'b1, 8'h04, 16'h00C3, 1'b0, 3'd2, 3'd0, 16'h00C3, 16'h5555, 3'b001, 1'b0};
        vecs[9]  = '{1'b1, 8'h05, 16'hBEEF, 1'b1, 3'd0, 3'd2, 16'h5555, 16'h00C3, 3'b100, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 16'h0000, 1'b0, 3'd0, 3'd2, 16'h5555, 16'h00C3, 3'b100, 1'b0};
        vecs[11] = '{1'b1, 8'h00, 16'hBEEF, 1'b0, 3'd0, 3'd2, 16'h5555, 16'h00C3, 3'b100, 1'b1};
        vecs[12] = '{1'b1, 8'h80, 16'h7FFF, 1'b1, 3'd7, 3'd7, 16'h7FFF, 16'h7FFF, 3'b001, 1'b0};
        vecs[13] = '{1'b0, 8'h05, 16'h1111, 1'b0, 3'd0, 3'd2, 16'h5555, 16'h00C3, 3'b001, 1'b0};
        vecs[14] = '{1'b1, 8'h02, 16'h0F0F, 1'b0, 3'd1, 3'd7, 16'h0F0F, 16'h7FFF, 3'b001, 1'b0};
        vecs[15] = '{1'b1, 8'hFF, 16'hDEAD, 1'b0, 3'd1, 3'd6, 16'h0F0F, 16'h0000, 3'b001, 1'b1};
        vecs[16] = '{1'b1, 8'h03, 16'hDEAD, 1'b0, 3'd1, 3'd0, 16'h0F0F, 16'h5555, 3'b001, 1'b1};
        vecs[17] = '{1'b1, 8'h40, 16'h1111, 1'b0, 3'd6, 3'd1, 16'h1111, 16'h0F0F, 3'b001, 1'b0};
        vecs[18] = '{1'b1, 8'h40, 16'h2222, 1'b0, 3'd6, 3'd6, 16'h2222, 16'h2222, 3'b001, 1'b0};

        rst_n     = 1'b0;
        ld_reg    = 1'b0;
        dr_onehot = 8'h00;
        bus_in    = 16'h0000;
        ld_cc     = 1'b0;
        sr1       = 3'd0;
        sr2       = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkAllZero("reset");

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Same-cycle read of a register being written
        @(negedge clk);
        ld_reg    = 1'b1;
        dr_onehot = 8'h80;
        bus_in    = 16'hAAAA;
        sr1       = 3'd7;
        sr2       = 3'd6;
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("r7_same_cycle", sr1_out, 16'hAAAA);
`else
        checkOutput("r7_same_cycle", sr1_out, 16'h7FFF);
`endif
        checkOutput("r6_not_bypassed", sr2_out, 16'h2222);
        @(posedge clk);
        #1;
        ld_reg    = 1'b0;
        dr_onehot = 8'h00;
        #1;
        checkOutput("r7_next_cycle", sr1_out, 16'hAAAA);

        // Illegal select with the bus matching R7's index must not forward
        @(negedge clk);
        ld_reg    = 1'b1;
        dr_onehot = 8'hC0;
        bus_in    = 16'h3333;
        sr1       = 3'd7;
        #1;
        checkOutput("no_bypass_illegal", sr1_out, 16'hAAAA);

        // Mid-cycle reset while the error flag and registers are live
        @(posedge clk);
        #1;
        ld_reg    = 1'b0;
        dr_onehot = 8'h00;
        #1;
        checkOutput("pre_reset_err", {15'b0, onehot_err}, 16'h0001);
        checkOutput("pre_reset_r7", sr1_out, 16'hAAAA);
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");

        // First edge after reset release performs a normal write
        @(negedge clk);
        rst_n     = 1'b1;
        ld_reg    = 1'b1;
        dr_onehot = 8'h20;
        bus_in    = 16'h0055;
        ld_cc     = 1'b1;
        @(posedge clk);
        #1;
        ld_reg    = 1'b0;
        ld_cc     = 1'b0;
        dr_onehot = 8'h00;
        sr1       = 3'd5;
        sr2       = 3'd7;
        #1;
        checkOutput("post_reset_r5", sr1_out, 16'h0055);
        checkOutput("post_reset_r7", sr2_out, 16'h0000);
        checkOutput("post_reset_nzp", {13'b0, nzp}, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
